// File: rtl/req_ack_stream_source.sv
// Purpose : host-fed FIFO that answers a req/ack requester with one word per one-cycle ack pulse.
// Latency : req with data at edge N -> dout valid after N, ack high after N+1; at most one word every 3 cycles.
// Backpress: requester paces delivery through req; host sees full and pushes while full are dropped (sticky overflow).
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   wr_en, wr_data      host push strobe and word
//   full, empty, level  FIFO status, combinational from the pointers
//   overflow            sticky flag: a push was attempted while full
//   req                 level request from the downstream requester
//   ack, dout           registered one-cycle acknowledge and the word it delivers
//   count               words delivered since reset (wraps at 2**32)
//   stall_cycles        cycles spent idle with req high and nothing to send
//
// Build option: define REQ_ACK_STREAM_SOURCE_STATS_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.

// Generic circular-buffer FIFO. Pointers carry one extra bit so full and
// empty can be told apart when the index bits match.
module req_ack_stream_source_fifo #(
  parameter int data_width = 32,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_dat,
  input  logic                  pop,
  output logic [data_width-1:0] head_dat,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level
);

  localparam int depth = 1 << depth_log2;

  logic [data_width-1:0] mem [depth];
  logic [depth_log2:0]   wr_ptr;
  logic [depth_log2:0]   rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (wr_ptr[depth_log2] != rd_ptr[depth_log2]) &&
                 (wr_ptr[depth_log2-1:0] == rd_ptr[depth_log2-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  // Modular subtraction gives the occupancy even across pointer wrap.
  assign level = wr_ptr - rd_ptr;

  // Full/empty are judged on the pre-edge pointers, so a push while full is
  // dropped even if a pop happens on the same edge.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr[depth_log2-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[depth_log2-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

module req_ack_stream_source #(
  parameter int data_width = 32,
  parameter int depth_log2 = 4,
  parameter int source_id  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   level,
  output logic                  overflow,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [31:0]           count,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state;
  logic                  pop;
  logic [data_width-1:0] head_dat;

  // source_id only tags an instance for debug; nothing is built from it.
  if (source_id < 0) begin : g_negative_source_id
  end

  // The word is committed to the requester at the moment it is popped.
  assign pop = (state == IDLE) && req && !empty;

  req_ack_stream_source_fifo #(
    .data_width (data_width),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .push_dat (wr_data),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  // IDLE pops into dout, LOAD gives dout a full settled cycle before ack
  // rises, ACK holds ack for exactly one cycle. dout only changes on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      dout  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (pop) begin
            state <= LOAD;
            dout  <= head_dat;
          end
        end
        LOAD: begin
          state <= ACK;
          ack   <= 1'b1;
          count <= count + 32'd1;
        end
        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REQ_ACK_STREAM_SOURCE_STATS_EN
  // Starvation: requester is asking but there is nothing to hand over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && req && empty && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_req_ack_stream_source.sv
module tb_req_ack_stream_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        req;
  logic        ack;
  logic [31:0] dout;
  logic [31:0] count;
  logic [31:0] stall_cycles;

`ifdef REQ_ACK_STREAM_SOURCE_STATS_EN
  localparam logic [31:0] STALL_EXP = 32'd10;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  req_ack_stream_source #(
    .data_width (32),
    .depth_log2 (4),
    .source_id  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .req          (req),
    .ack          (ack),
    .dout         (dout),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ack_cnt  = 0;
  int          last_cyc = 0;
  bit          last_valid = 0;
  bit          spacing_en = 0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_dout = '0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack pops the scoreboard and checks the delivered word.
  always @(negedge clk) begin
    if (!rst && ack) begin
      logic [31:0] e;
      ack_cnt++;
      chk("ack_not_back_to_back", {63'd0, prev_ack}, 64'd0);
      chk("dout_stable_before_ack", {32'd0, dout}, {32'd0, prev_dout});
      chk("ack_with_word_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ack_dout", {32'd0, dout}, {32'd0, e});
      end
      if (spacing_en && last_valid)
        chk("ack_spacing", 64'(cyc - last_cyc), 64'd3);
      last_cyc   = cyc;
      last_valid = 1;
    end
    prev_ack  = ack;
    prev_dout = dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && ack_cnt < target; i++) step();
    chk("ack_wait_budget", {63'd0, ack_cnt >= target}, 64'd1);
  endtask

  task automatic do_reset();
    req   = 1'b0;
    wr_en = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    last_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    req     = 1'b0;
    #12;
    chk("rst_ack",      {63'd0, ack},      64'd0);
    chk("rst_empty",    {63'd0, empty},    64'd1);
    chk("rst_full",     {63'd0, full},     64'd0);
    chk("rst_level",    {59'd0, level},    64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_dout",     {32'd0, dout},     64'd0);
    chk("rst_count",    {32'd0, count},    64'd0);
    chk("rst_stall",    {32'd0, stall_cycles}, 64'd0);
    step();
    rst = 1'b0;

    // Reset in the middle of a transfer with words still queued.
    push_word(32'h1, 1);
    push_word(32'h2, 1);
    push_word(32'h3, 1);
    chk("pre_rst_level", {59'd0, level}, 64'd3);
    req = 1'b1;
    for (int i = 0; i < 20 && !ack; i++) step();
    chk("pre_rst_ack_seen", {63'd0, ack}, 64'd1);
    #5;
    rst = 1'b1;
    #1;
    chk("midrst_ack",   {63'd0, ack},   64'd0);
    chk("midrst_empty", {63'd0, empty}, 64'd1);
    chk("midrst_level", {59'd0, level}, 64'd0);
    chk("midrst_count", {32'd0, count}, 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    base = ack_cnt;
    // req stays high on an empty FIFO: no ack, starvation counted.
    for (int i = 0; i < 9; i++) step();
    chk("post_rst_no_ack", 64'(ack_cnt), 64'(base));
    push_word(32'h55, 1);
    wait_acks(base + 1, 20);
    chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, STALL_EXP});
    chk("stall_count",  {32'd0, count}, 64'd1);
    req = 1'b0;

    // Single transfer with exact latency.
    do_reset();
    req = 1'b1;
    push_word(32'h0000_00A5, 1);
    step();
    chk("single_dout_early", {32'd0, dout}, 64'hA5);
    chk("single_ack_low",    {63'd0, ack},  64'd0);
    step();
    chk("single_ack_high",   {63'd0, ack},   64'd1);
    chk("single_count",      {32'd0, count}, 64'd1);
    chk("single_level",      {59'd0, level}, 64'd0);
    step();
    chk("single_ack_one_cycle", {63'd0, ack}, 64'd0);
    req = 1'b0;

    // Fill to full, overflow, then stream out at full rate.
    do_reset();
    for (int i = 0; i < 15; i++) push_word(32'(i), 1);
    chk("fill15_level", {59'd0, level}, 64'd15);
    chk("fill15_full",  {63'd0, full},  64'd0);
    push_word(32'd15, 1);
    chk("fill16_full",     {63'd0, full},     64'd1);
    chk("fill16_level",    {59'd0, level},    64'd16);
    chk("fill16_overflow", {63'd0, overflow}, 64'd0);
    push_word(32'hDEAD_BEEF, 0);
    chk("ovf_flag",  {63'd0, overflow}, 64'd1);
    chk("ovf_level", {59'd0, level},    64'd16);
    base = ack_cnt;
    spacing_en = 1;
    req = 1'b1;
    wait_acks(base + 16, 80);
    spacing_en = 0;
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_count", {32'd0, count}, 64'd16);

    // Concurrent pushes and pops across the pointer wrap.
    base = ack_cnt;
    for (int i = 0; i < 20; i++) begin
      push_word(32'd100 + 32'(i), 1);
      chk("wrap_level_le16", {63'd0, level <= 5'd16}, 64'd1);
    end
    wait_acks(base + 20, 100);
    chk("wrap_empty",    {63'd0, empty},    64'd1);
    chk("wrap_count",    {32'd0, count},    64'd36);
    chk("wrap_overflow_sticky", {63'd0, overflow}, 64'd1);
    req = 1'b0;

    // Push on the same edge as the IDLE->LOAD pop; req drops mid-transfer.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(32'd200 + 32'(i), 1);
    chk("simul_pre_level", {59'd0, level}, 64'd5);
    req     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'd205;
    exp_q.push_back(32'd205);
    step();
    wr_en = 1'b0;
    req   = 1'b0;
    chk("simul_level", {59'd0, level}, 64'd5);
    chk("simul_dout",  {32'd0, dout},  64'd200);
    base = ack_cnt;
    step();
    chk("req_drop_ack", {63'd0, ack}, 64'd1);
    req = 1'b1;
    wait_acks(base + 6, 40);
    chk("simul_empty", {63'd0, empty}, 64'd1);
    chk("simul_count", {32'd0, count}, 64'd6);
    req = 1'b0;
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
